// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR fetch stage with one-deep skid buffer and response draining on redirect/flush.
module fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  FETCH_Clk,
    input  logic                  FETCH_Reset,
    input  logic                  FETCH_Pc_Reset,
    input  logic                  FETCH_Enpc,
    input  logic                  FETCH_Ir_Reset,
    input  logic                  FETCH_Ir_Set,
    input  logic                  FETCH_Insmem_Read,
    output logic                  FETCH_Mem_Req,
    output logic [ADDR_WIDTH-1:0] FETCH_Mem_Addr,
    input  logic                  FETCH_Mem_Rvalid,
    input  logic [DATA_WIDTH-1:0] FETCH_Mem_Rdata,
    input  logic                  FETCH_Redirect,
    input  logic [ADDR_WIDTH-1:0] FETCH_Redirect_Pc,
    output logic [DATA_WIDTH-1:0] FETCH_Ir,
    output logic [ADDR_WIDTH-1:0] FETCH_Ir_Pc,
    output logic                  FETCH_Ir_Valid,
    input  logic                  FETCH_Ir_Ready
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
    state_t r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc, r_ir_pc, r_skid_pc, w_redirect_pc;
    logic [DATA_WIDTH-1:0] r_ir, r_skid;
    logic r_ir_valid, w_flush, w_fetch_en, w_rsp, w_load, w_skid_wr, w_unskid;
    assign w_flush       = FETCH_Pc_Reset | FETCH_Redirect;
    assign w_fetch_en    = FETCH_Insmem_Read & FETCH_Enpc & FETCH_Ir_Set & ~w_flush & ~FETCH_Ir_Reset;
    assign w_redirect_pc = FETCH_Redirect_Pc & ~ADDR_WIDTH'(3);
    assign w_rsp         = (r_state == S_WAIT) & FETCH_Mem_Rvalid;
    // An IR reset in the same cycle frees the IR, so the response may load it directly
    assign w_load        = w_rsp & ~w_flush & (~r_ir_valid | FETCH_Ir_Ready | FETCH_Ir_Reset);
    assign w_skid_wr     = w_rsp & ~w_flush & ~w_load;
    assign w_unskid      = (r_state == S_HOLD) & r_ir_valid & FETCH_Ir_Ready & ~w_flush & ~FETCH_Ir_Reset;
    always_ff @(posedge FETCH_Clk) begin
        if (FETCH_Reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_fetch_en ? S_REQ : S_IDLE;
            S_REQ:   w_next = w_flush ? S_DRAIN : S_WAIT;
            S_WAIT:  w_next = !FETCH_Mem_Rvalid ? (w_flush ? S_DRAIN : S_WAIT)
                            : w_flush ? S_IDLE : w_load ? (w_fetch_en ? S_REQ : S_IDLE) : S_HOLD;
            S_HOLD:  w_next = (w_flush | FETCH_Ir_Reset | FETCH_Ir_Ready) ? S_IDLE : S_HOLD;
            S_DRAIN: w_next = FETCH_Mem_Rvalid ? S_IDLE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end
    always_comb begin
        FETCH_Mem_Req  = (r_state == S_REQ);
        FETCH_Mem_Addr = r_pc;
        FETCH_Ir       = r_ir;
        FETCH_Ir_Pc    = r_ir_pc;
        FETCH_Ir_Valid = r_ir_valid;
    end
    always_ff @(posedge FETCH_Clk) begin
        if (FETCH_Reset) begin
            r_pc       <= RESET_VECTOR;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_skid     <= '0;
            r_skid_pc  <= '0;
        end else begin
            if (FETCH_Pc_Reset)
                r_pc <= RESET_VECTOR;
            else if (FETCH_Redirect)
                r_pc <= w_redirect_pc;
            else if (w_rsp)
                r_pc <= r_pc + ADDR_WIDTH'(4);
            if (w_load) begin
                r_ir    <= FETCH_Mem_Rdata;
                r_ir_pc <= r_pc;
            end else if (w_unskid) begin
                r_ir    <= r_skid;
                r_ir_pc <= r_skid_pc;
            end
            r_ir_valid <= w_load | w_unskid | (r_ir_valid & ~w_flush & ~FETCH_Ir_Reset & ~FETCH_Ir_Ready);
            if (w_skid_wr) begin
                r_skid    <= FETCH_Mem_Rdata;
                r_skid_pc <= r_pc;
            end
        end
    end
endmodule
